sr_iter_shifter: RTL and testbench
==================================

Name: sr_iter_shifter

Overview:
- Multi-cycle 32-bit right shifter: logical (SRL) and arithmetic (SRA).
- Complements the fixed left-shift stages in the processor ALU shift path.
- Decomposes the 5-bit shift amount into conditional shifts by 16, 8, 4, 2 and 1, one per cycle, so a single narrow stage is reused.
- Sits beside the ALU; the execute stage issues operands via a valid/ready handshake and stalls until the result is accepted.

Parameters:
- WIDTH, 32, data width; must be 32.
- SHAMT_W, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operands present on in_data/in_shamt/in_arith.
- in_ready  output  1  unit can accept a new operation.
- in_data  input  32  value to shift.
- in_shamt  input  5  shift amount, 0..31.
- in_arith  input  1  1 = SRA (sign fill); 0 = SRL (zero fill).
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_data=0; internal accumulator=0; stage counter=0.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge.
  - Latch the data into the accumulator, plus in_shamt, in_arith and fill bit = in_arith & in_data[31].
  - Go to SHIFT with k=4.
- SHIFT, one cycle per k (4,3,2,1,0):
  - If shamt[k]=1, accumulator <= accumulator >> 2^k, with the top 2^k bits = fill.
  - Otherwise the accumulator is unchanged.
  - k decrements; after k=0 go to DONE.
  - SHIFT always lasts exactly 5 cycles; there is no early exit for small amounts (fixed latency).
- DONE:
  - out_valid=1; out_data = accumulator, held stable until out_valid && out_ready.
  - On that handshake: go to IDLE, out_valid=0.
  - out_data keeps the last value; consumers must not rely on it when out_valid=0.
- Latency: accept edge to out_valid high is 5 cycles; earliest next accept is 7 cycles after the previous accept.
- in_ready = (state==IDLE). No acceptance in SHIFT or DONE, and no back-to-back pipelining.
- out_ready held high in DONE: completes on the first DONE edge. IDLE is reached the next cycle; in_ready rises then.
- Input operands may change freely after acceptance; only latched copies are used.
- Boundaries:
  - shamt=0 → result equals the input.
  - shamt=31 SRL → result is 0 or 1.
  - shamt=31 SRA → result is all fill bits, 0x00000000 or 0xFFFFFFFF.
  - in_arith=1 with a positive input → identical to SRL.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE with the reset values; the pending result is discarded and out_valid is never asserted for it.
- in_valid high while not in IDLE: ignored, with no side effect.
- Arithmetic: pure bit moves; no overflow; width stays 32 throughout.

Decomposition:
- Shared package shift_pkg:
  - State encoding constants: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - SHAMT_W and WIDTH constants.
  - Stage-amount table 16/8/4/2/1 indexed by k.
- One natural sub-module: sr_stage.
  - Combinational: out = en ? {fill x 2^k, in[31:2^k]} : in.
  - k is selected by a 3-bit index.
  - Instantiated once and fed by the accumulator.
- Top level holds the FSM, counter, latches and handshake.

Test Plan:
- Reset during idle: reset=0 → in_ready=1, out_valid=0, busy=0, out_data=0. Release → unchanged until in_valid.
- SRL: in_data=0xF000_0000, shamt=4, arith=0 → out_valid exactly 5 cycles after accept, out_data=0x0F00_0000.
- SRA: in_data=0x8000_0000, shamt=31, arith=1 → 0xFFFF_FFFF. Same with arith=0 → 0x0000_0001. shamt=0 on 0x1234_5678 → 0x1234_5678.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid stays 1 and out_data stable. in_valid pulses with new data are ignored and in_ready stays 0. Raising out_ready → one transfer, IDLE next cycle.
- Reset mid-operation: assert reset 2 cycles after accept → out_valid never rises; in_ready=1 right after release. A next op 0x0000_00FF>>3 SRL returns 0x0000_001F.
- Random sweep: 1000 random (data, shamt, arith) with random out_ready stalls; compare against a >> / >>> reference model. Every accepted op yields exactly one out_valid handshake.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants, state encoding and stage-amount table for the iterative right shifter.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Shift distance per stage index k; unused indices shift by zero.
  localparam logic [SHAMT_W-1:0] STAGE_AMT [8] = '{
    5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd0, 5'd0
  };

  function automatic logic [SHAMT_W-1:0] stage_amt(input logic [2:0] k);
    return STAGE_AMT[k];
  endfunction

endpackage

// File: rtl/sr_stage.sv
// One conditional right-shift stage: shifts by 2^k with the vacated top bits set to fill.
module sr_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       k_idx,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] out_data
);

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   fill_mask;

  always_comb begin
    amt       = stage_amt(k_idx);
    fill_mask = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
    out_data  = en ? ((in_data >> amt) | fill_mask) : in_data;
  end

endmodule

// File: rtl/sr_iter_shifter.sv
// Multi-cycle 32-bit SRL/SRA: one stage reused over five cycles (k = 4..0), fixed latency,
// valid/ready on both sides.
module sr_iter_shifter
  import shift_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [2:0]         k_q, k_d;
  logic               fill_q, fill_d;
  logic               out_valid_q, out_valid_d;
  logic               stage_en;
  logic [WIDTH-1:0]   stage_out;

  assign stage_en = (state_q == S_SHIFT) && shamt_q[k_q];

  sr_stage u_stage (
    .in_data  (acc_q),
    .k_idx    (k_q),
    .en       (stage_en),
    .fill     (fill_q),
    .out_data (stage_out)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    shamt_d     = shamt_q;
    k_d         = k_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          shamt_d = in_shamt;
          fill_d  = in_arith & in_data[WIDTH-1];
          k_d     = 3'd4;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = stage_out;
        if (k_q == 3'd0) begin
          out_data_d  = stage_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      shamt_q     <= '0;
      k_q         <= '0;
      fill_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      shamt_q     <= shamt_d;
      k_q         <= k_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sr_iter_shifter.sv
// Directed and randomised checks of sr_iter_shifter against hand values and a >>/>>> model.
module tb_sr_iter_shifter;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int numChecks = 0;
  int numErrors = 0;
  int acceptCnt = 0;
  int handshakeCnt = 0;

  sr_iter_shifter dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset && in_valid && in_ready) acceptCnt++;
    if (reset && out_valid && out_ready) handshakeCnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, issues one operation, then measures cycles until out_valid.
  task automatic applyStimulus(input logic [31:0] data, input logic [4:0] shamt, input logic arith,
                               input string tag);
    int waitCnt = 0;
    int lat = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!in_ready) checkOutput({tag, " ready timeout"}, {31'b0, in_ready}, 32'd1);
    in_data  = data;
    in_shamt = shamt;
    in_arith = arith;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom_range(0, 31));
    in_arith = ~arith;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd5);
  endtask

  task automatic collectResult(input logic [31:0] expected, input int stall, input string tag);
    out_ready = 1'b0;
    repeat (stall) @(negedge clock);
    checkOutput({tag, " data"}, out_data, expected);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput({tag, " valid drop"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, " ready back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] expv;
    logic [4:0]  s;
    logic        a;
    int          accSnap;
    int          hsSnap;
    logic        sawValid;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clock);
    checkOutput("rst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    checkOutput("rst out_data", out_data, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("post-rst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post-rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("post-rst busy", {31'b0, busy}, 32'd0);

    applyStimulus(32'hF000_0000, 5'd4, 1'b0, "srl4");
    checkOutput("srl4 busy", {31'b0, busy}, 32'd1);
    checkOutput("srl4 in_ready", {31'b0, in_ready}, 32'd0);
    collectResult(32'h0F00_0000, 0, "srl4");

    applyStimulus(32'h8000_0000, 5'd31, 1'b1, "sra31");
    collectResult(32'hFFFF_FFFF, 0, "sra31");
    applyStimulus(32'h8000_0000, 5'd31, 1'b0, "srl31");
    collectResult(32'h0000_0001, 1, "srl31");
    applyStimulus(32'h7FFF_FFFF, 5'd31, 1'b0, "srl31 pos");
    collectResult(32'h0000_0000, 0, "srl31 pos");
    applyStimulus(32'h1234_5678, 5'd0, 1'b1, "shamt0");
    collectResult(32'h1234_5678, 0, "shamt0");
    applyStimulus(32'h7FFF_0000, 5'd12, 1'b1, "sra pos");
    collectResult(32'h0007_FFF0, 0, "sra pos");
    applyStimulus(32'hC000_0001, 5'd21, 1'b1, "sra21");
    collectResult(32'hFFFF_FE00, 0, "sra21");

    // Backpressure in DONE with ignored in_valid pulses.
    applyStimulus(32'h8765_4321, 5'd8, 1'b1, "bp");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      @(negedge clock);
      checkOutput("bp hold valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp hold data", out_data, 32'hFF87_6543);
      checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    collectResult(32'hFF87_6543, 0, "bp");
    repeat (7) @(negedge clock);
    checkOutput("bp no ghost op", {31'b0, out_valid}, 32'd0);

    // Reset while shifting discards the operation.
    in_data  = 32'hDEAD_BEEF;
    in_shamt = 5'd3;
    in_arith = 1'b1;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst out_data", out_data, 32'h0);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 1) reset = 1'b1;
      sawValid = sawValid | out_valid;
      if (i == 2) checkOutput("midrst ready after", {31'b0, in_ready}, 32'd1);
    end
    checkOutput("midrst no valid", {31'b0, sawValid}, 32'd0);
    applyStimulus(32'h0000_00FF, 5'd3, 1'b0, "after rst");
    collectResult(32'h0000_001F, 0, "after rst");

    accSnap = acceptCnt;
    hsSnap  = handshakeCnt;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      if (a) expv = $signed(d) >>> s;
      else   expv = d >> s;
      applyStimulus(d, s, a, "rand");
      collectResult(expv, $urandom_range(0, 3), "rand");
    end
    checkOutput("rand accepts", 32'(acceptCnt - accSnap), 32'd1000);
    checkOutput("rand handshakes", 32'(handshakeCnt - hsSnap), 32'd1000);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
